// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART byte receiver.
// Contents:
//   rx_state_t  - receiver FSM state encoding
//   bit_cycles  - clock cycles per serial bit for a given clock (MHz) and baud rate
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } rx_state_t;

  function automatic int unsigned bit_cycles(input int unsigned clk_mhz,
                                             input int unsigned baud);
    return (clk_mhz * 1_000_000) / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for a single asynchronous input bit.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset; both stages load ResetVal
//   d      in  asynchronous input
//   q      out synchronized output (two-cycle latency)
module sync_2ff #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_byte_receiver.sv
// 8N1 UART receiver delivering bytes over a valid/ready handshake.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx         in   raw serial line, idle high, asynchronous to clk
//   data       out  received byte, stable while valid is high
//   valid      out  byte available, held until accepted
//   ready      in   consumer accepts on a clk edge with valid & ready
//   overrun    out  sticky: a byte was dropped because the previous one was not accepted
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
module uart_rx_byte_receiver
  import uart_pkg::*;
#(
  parameter int unsigned ClkMhz   = 50,
  parameter int unsigned BaudRate = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       overrun,
  output logic       frame_err
);

  localparam int unsigned BitCycles  = bit_cycles(ClkMhz, BaudRate);
  localparam int unsigned HalfCycles = BitCycles / 2;
  localparam int unsigned CntW       = (BitCycles > 1) ? $clog2(BitCycles) : 1;
  localparam logic [CntW-1:0] BitLast  = CntW'(BitCycles - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfCycles - 1);

  logic rx_s;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
  sync_2ff #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  rx_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_done;
  logic            fe_set;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    fe_set    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        // Re-check the start bit at its centre; a high level here was only a glitch.
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = StData;
            bit_idx_d = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};  // LSB arrives first
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_done = 1'b1;
            state_d   = StIdle;
          end else begin
            fe_set  = 1'b1;
            state_d = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitHigh: begin
        // A held-low break must not restart reception until the line recovers.
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  logic [7:0] data_q;
  logic       valid_q;
  logic       overrun_q;
  logic       frame_err_q;
  logic       accept;
  logic       drop;

  assign accept = valid_q & ready;
  assign drop   = byte_done & valid_q & ~ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= fe_set;
      if (byte_done && !drop) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
      // Setting wins over the clear caused by an acceptance on the same edge.
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (accept) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_byte_receiver.sv
module tb_uart_rx_byte_receiver;

  localparam int unsigned ClkMhz   = 8;
  localparam int unsigned BaudRate = 500000;
  localparam int Bit  = 16;  // 8 MHz / 500 kbaud
  localparam int Half = Bit / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       overrun;
  logic       frame_err;

  initial forever #5 clk = ~clk;

  uart_rx_byte_receiver #(
    .ClkMhz  (ClkMhz),
    .BaudRate(BaudRate)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Passive monitor, samples on the falling edge.
  logic [7:0] got_q[$];
  int         fe_cnt, fe_run, fe_run_max, vrun, vrun_max, stab_err;
  logic       prev_valid = 1'b0, prev_acc = 1'b0;
  logic [7:0] prev_data = 8'h00;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_valid = 1'b0;
      fe_run     = 0;
      vrun       = 0;
    end else begin
      if (valid && ready) got_q.push_back(data);
      if (prev_valid && valid && !prev_acc && data !== prev_data) stab_err++;
      prev_valid = valid;
      prev_data  = data;
      prev_acc   = valid && ready;
      if (frame_err) begin
        fe_cnt++;
        fe_run++;
        if (fe_run > fe_run_max) fe_run_max = fe_run;
      end else fe_run = 0;
      if (valid) begin
        vrun++;
        if (vrun > vrun_max) vrun_max = vrun;
      end else vrun = 0;
    end
  end

  task automatic clr();
    got_q.delete();
    fe_cnt     = 0;
    fe_run_max = 0;
    vrun_max   = 0;
    stab_err   = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (Bit) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         nbytes;
    logic [7:0] exp_data;
    int         nfe;
  } vec_t;

  vec_t vecs[7];

  // Reference model state for the randomized phase.
  logic       m_pend;
  logic [7:0] m_byte;
  logic       m_ovr;
  logic [7:0] exp_q[$];
  int         n;

  initial begin
    vecs[0] = '{b: 8'hA5, stop: 1'b1, nbytes: 1, exp_data: 8'hA5, nfe: 0};
    vecs[1] = '{b: 8'h3C, stop: 1'b1, nbytes: 1, exp_data: 8'h3C, nfe: 0};
    vecs[2] = '{b: 8'h55, stop: 1'b0, nbytes: 0, exp_data: 8'h00, nfe: 1};
    vecs[3] = '{b: 8'h0F, stop: 1'b1, nbytes: 1, exp_data: 8'h0F, nfe: 0};
    vecs[4] = '{b: 8'h00, stop: 1'b1, nbytes: 1, exp_data: 8'h00, nfe: 0};
    vecs[5] = '{b: 8'hFF, stop: 1'b0, nbytes: 0, exp_data: 8'h00, nfe: 1};
    vecs[6] = '{b: 8'h01, stop: 1'b1, nbytes: 1, exp_data: 8'h01, nfe: 0};

    clr();
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_valid", valid, 1'b0);
    check("reset_data", data, 8'h00);
    check("reset_overrun", overrun, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    rst_n = 1'b1;
    idle(Bit);

    // 0xA5 with latency measurement; rx falls just after an edge, so the first
    // capturing edge is one tick later than the fall.
    clr();
    ready = 1'b1;
    n = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!valid && n < 12 * Bit) begin
          tick();
          n++;
        end
      end
    join
    idle(2 * Bit);
    check("a5_latency", n, 1 + 2 + Half + 9 * Bit);
    check("a5_count", got_q.size(), 1);
    check("a5_data", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'hA5);
    check("a5_valid_width", vrun_max, 1);
    check("a5_overrun", overrun, 1'b0);
    check("a5_frame_err", fe_cnt, 0);

    // Table-driven frames with ready held high.
    foreach (vecs[i]) begin
      clr();
      ready = 1'b1;
      send_frame(vecs[i].b, vecs[i].stop);
      idle(2 * Bit);
      check($sformatf("vec%0d_count", i), got_q.size(), vecs[i].nbytes);
      if (vecs[i].nbytes > 0)
        check($sformatf("vec%0d_data", i), (got_q.size() > 0) ? got_q[0] : 8'hxx,
              vecs[i].exp_data);
      check($sformatf("vec%0d_fe", i), fe_cnt, vecs[i].nfe);
      check($sformatf("vec%0d_fe_width", i), fe_run_max, vecs[i].nfe);
      check($sformatf("vec%0d_valid", i), valid, 1'b0);
    end

    // Short low glitch well under half a bit is rejected.
    clr();
    rx = 1'b0;
    repeat (4) tick();
    idle(2 * Bit);
    check("glitch_count", got_q.size(), 0);
    check("glitch_fe", fe_cnt, 0);
    send_frame(8'h3C, 1'b1);
    idle(2 * Bit);
    check("after_glitch_data", (got_q.size() == 1) ? got_q[0] : 8'hxx, 8'h3C);

    // Overrun: two bytes with no consumer.
    clr();
    ready = 1'b0;
    send_frame(8'h11, 1'b1);
    idle(2 * Bit);
    send_frame(8'h22, 1'b1);
    idle(2 * Bit);
    check("ovr_valid", valid, 1'b1);
    check("ovr_data", data, 8'h11);
    check("ovr_flag", overrun, 1'b1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("ovr_valid_after_accept", valid, 1'b0);
    check("ovr_flag_after_accept", overrun, 1'b0);
    check("ovr_accepted", (got_q.size() == 1) ? got_q[0] : 8'hxx, 8'h11);
    check("ovr_stable", stab_err, 0);

    // Reset in the middle of data bit 4, with a byte and overrun pending.
    send_frame(8'h77, 1'b1);
    idle(2 * Bit);
    send_frame(8'h78, 1'b1);
    idle(2 * Bit);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (Half) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", valid, 1'b0);
    check("midrst_data", data, 8'h00);
    check("midrst_overrun", overrun, 1'b0);
    check("midrst_frame_err", frame_err, 1'b0);
    repeat (3) tick();
    rx = 1'b1;
    rst_n = 1'b1;
    idle(2 * Bit);
    clr();
    ready = 1'b1;
    send_frame(8'h80, 1'b1);
    idle(2 * Bit);
    check("postrst_count", got_q.size(), 1);
    check("postrst_data", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'h80);
    check("postrst_fe", fe_cnt, 0);

    // Break: line low for 20 bit times gives exactly one frame error.
    clr();
    rx = 1'b0;
    repeat (20 * Bit) tick();
    idle(2 * Bit);
    check("break_fe", fe_cnt, 1);
    check("break_count", got_q.size(), 0);
    send_frame(8'hC3, 1'b1);
    idle(2 * Bit);
    check("after_break_data", (got_q.size() == 1) ? got_q[0] : 8'hxx, 8'hC3);

    // Randomized frames against an abstract delivery model: a single holding
    // slot, a sticky loss flag, and the ordered list of bytes the consumer sees.
    clr();
    exp_q.delete();
    m_pend = 1'b0;
    m_byte = 8'h00;
    m_ovr  = 1'b0;
    for (int f = 0; f < 30; f++) begin
      logic [7:0] b;
      logic       good;
      logic       r;
      int         fe_before;
      b         = 8'($urandom);
      good      = ($urandom_range(0, 4) != 0);
      r         = 1'($urandom_range(0, 1));
      fe_before = fe_cnt;
      ready     = r;
      send_frame(b, good);
      idle(2 * Bit);
      if (r) begin
        if (m_pend) exp_q.push_back(m_byte);
        if (good) exp_q.push_back(b);
        m_pend = 1'b0;
        m_ovr  = 1'b0;
      end else if (good) begin
        if (m_pend) m_ovr = 1'b1;
        else begin
          m_pend = 1'b1;
          m_byte = b;
        end
      end
      check($sformatf("rnd%0d_valid", f), valid, m_pend);
      check($sformatf("rnd%0d_overrun", f), overrun, m_ovr);
      check($sformatf("rnd%0d_fe", f), fe_cnt - fe_before, good ? 0 : 1);
      if (m_pend) check($sformatf("rnd%0d_data", f), data, m_byte);
    end
    ready = 1'b1;
    if (m_pend) exp_q.push_back(m_byte);
    idle(4);
    check("rnd_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rnd_byte%0d", i), (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
    check("rnd_stable", stab_err, 0);
    check("rnd_fe_width", (fe_run_max <= 1) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
